// File: rtl/avalon_s_arbiter.sv
// avalon_s_arbiter: merges NH Avalon-MM host ports onto one device port.
// Arbitration is zero-cycle. The grant is locked while the device stalls.
// Read data returns one cycle after an accepted read and is steered to the
// host that issued that read.
// Optional build macro: AVN_ARB_FIXED_PRIO_EN selects fixed priority, with
// host 0 highest. When it is undefined, arbitration is round-robin.

// Per-host return path: stall steering and read-data steering.
module avalon_s_arbiter_lane #(
  parameter int DW = 32,
  parameter int IW = 1,
  parameter int ID = 0
) (
  input  logic [IW-1:0] gnt,
  input  logic [IW-1:0] rd_id,
  input  logic          rd_pend,
  input  logic          device_waitrequest,
  input  logic [DW-1:0] device_readdata,
  output logic          waitrequest,
  output logic [DW-1:0] readdata
);
  assign waitrequest = (gnt == IW'(ID)) ? device_waitrequest : 1'b1;
  assign readdata    = (rd_pend && (rd_id == IW'(ID))) ? device_readdata : '0;
endmodule

module avalon_s_arbiter #(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NH-1:0]              hosts_avn_read,
  input  logic [NH-1:0]              hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]      hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]    hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]      hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]      hosts_avn_readdata,
  output logic [NH-1:0]              hosts_avn_waitrequest,
  output logic                       device_avn_read,
  output logic                       device_avn_write,
  output logic [AW-1:0]              device_avn_address,
  output logic [DW/8-1:0]            device_avn_byte_enable,
  output logic [DW-1:0]              device_avn_writedata,
  input  logic [DW-1:0]              device_avn_readdata,
  input  logic                       device_avn_waitrequest
);
  localparam int IW = (NH > 1) ? $clog2(NH) : 1;

  logic [NH-1:0] req;
  logic [IW-1:0] gnt, lock_id, rd_id;
  logic          gnt_valid, accept, locked, rd_pend;

  // Grants are suppressed while reset is held, so the device port stays idle.
  assign req    = (hosts_avn_read | hosts_avn_write) & {NH{rst}};
  assign accept = gnt_valid & ~device_avn_waitrequest;

`ifdef AVN_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins unless a stalled grant is held.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    if (locked) begin
      gnt       = lock_id;
      gnt_valid = req[lock_id];
    end else begin
      for (int k = NH - 1; k >= 0; k--) begin
        if (req[IW'(k)]) begin
          gnt       = IW'(k);
          gnt_valid = 1'b1;
        end
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // Round-robin: first requester at or after rr_ptr. The search runs in reverse
  // so the last hit, which is the nearest to rr_ptr, wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_valid = 1'b0;
    if (locked) begin
      gnt       = lock_id;
      gnt_valid = req[lock_id];
    end else begin
      for (int k = NH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % NH;
        if (req[IW'(idx)]) begin
          gnt       = IW'(idx);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the host that completed a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_ptr <= '0;
    else if (accept) rr_ptr <= (gnt == IW'(NH - 1)) ? '0 : gnt + 1'b1;
  end
`endif

  // Lock the grant across device stalls, and track the one-cycle read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked  <= 1'b0;
      lock_id <= '0;
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      if (accept) begin
        locked <= 1'b0;
      end else if (gnt_valid) begin
        locked  <= 1'b1;
        lock_id <= gnt;
      end
      rd_pend <= accept & hosts_avn_read[gnt];
      if (accept && hosts_avn_read[gnt]) rd_id <= gnt;
    end
  end

  // The device port mirrors the granted host. With no grant, gnt is 0, so host 0 drives it.
  assign device_avn_read        = hosts_avn_read[gnt] & gnt_valid;
  assign device_avn_write       = hosts_avn_write[gnt] & gnt_valid;
  assign device_avn_address     = hosts_avn_address[gnt];
  assign device_avn_byte_enable = hosts_avn_byte_enable[gnt];
  assign device_avn_writedata   = hosts_avn_writedata[gnt];

  for (genvar i = 0; i < NH; i++) begin : g_lane
    avalon_s_arbiter_lane #(.DW(DW), .IW(IW), .ID(i)) u_lane (
      .gnt                (gnt),
      .rd_id              (rd_id),
      .rd_pend            (rd_pend),
      .device_waitrequest (device_avn_waitrequest),
      .device_readdata    (device_avn_readdata),
      .waitrequest        (hosts_avn_waitrequest[i]),
      .readdata           (hosts_avn_readdata[i])
    );
  end
endmodule
